// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the NOP word
// that pipeline registers load when flushed.
package pipe_ctrl_pkg;

   localparam logic [1:0] PC_RUN   = 2'd0;
   localparam logic [1:0] PC_FLUSH = 2'd1;
   localparam logic [1:0] PC_BUSY  = 2'd2;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID source register that matches the
// destination of a load currently in EX (x0 never hazards).
module pipe_ctrl_hazard_detect (
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_rs1_use,
   input  logic       id_rs2_use,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_reg_wen,
   input  logic       ex_is_load,
   output logic       load_use
);

   logic ex_load_wr;
   logic rs1_hit;
   logic rs2_hit;

   assign ex_load_wr = ex_is_load & ex_reg_wen & (ex_rd_addr != 5'd0);
   assign rs1_hit    = id_rs1_use & (id_rs1_addr == ex_rd_addr);
   assign rs2_hit    = id_rs2_use & (id_rs2_addr == ex_rd_addr);
   assign load_use   = ex_load_wr & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises EX busy, taken jumps, post-jump flush and
// load-use into hold/flush/redirect controls, and counts stall and jump events.
//
// state    | meaning
// PC_RUN   | normal issue, load-use checked
// PC_FLUSH | IF/ID flushed while the jump target refetches, count = cycles left
// PC_BUSY  | EX multi-cycle unit stalls everything; saved_q holds the state to resume
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_use,
   input  logic        id_rs2_use,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_reg_wen,
   input  logic        ex_is_load,
   input  logic        ex_jump_en,
   input  logic [31:0] ex_jump_addr,
   input  logic        ex_busy,
   output logic        hold_pc,
   output logic        hold_if_id,
   output logic        hold_id_ex,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        pc_redirect_en,
   output logic [31:0] pc_redirect_addr,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   logic [1:0]             state_q, state_d, saved_q, saved_d, eff_state;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic                   load_use;
   logic                   jump_acc;
   logic                   stall_evt;
   logic [31:0]            stall_cnt_q, flush_cnt_q;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .id_rs1_use  (id_rs1_use),
      .id_rs2_use  (id_rs2_use),
      .ex_rd_addr  (ex_rd_addr),
      .ex_reg_wen  (ex_reg_wen),
      .ex_is_load  (ex_is_load),
      .load_use    (load_use)
   );

   // Leaving BUSY behaves exactly like the state that was interrupted.
   assign eff_state = (state_q == PC_BUSY) ? saved_q : state_q;

   always_comb begin
      hold_pc          = 1'b0;
      hold_if_id       = 1'b0;
      hold_id_ex       = 1'b0;
      flush_if_id      = 1'b0;
      flush_id_ex      = 1'b0;
      pc_redirect_en   = 1'b0;
      pc_redirect_addr = 32'd0;
      jump_acc         = 1'b0;
      state_d          = state_q;
      saved_d          = saved_q;
      cnt_d            = cnt_q;

      if (ex_busy) begin
         hold_pc    = 1'b1;
         hold_if_id = 1'b1;
         hold_id_ex = 1'b1;
         state_d    = PC_BUSY;
         if (state_q != PC_BUSY) saved_d = state_q;
      end else if (ex_jump_en) begin
         jump_acc         = 1'b1;
         flush_if_id      = 1'b1;
         flush_id_ex      = 1'b1;
         pc_redirect_en   = 1'b1;
         pc_redirect_addr = ex_jump_addr;
         if (FLUSH_CYCLES > 1) begin
            state_d = PC_FLUSH;
            cnt_d   = FLUSH_LOAD;
         end else begin
            state_d = PC_RUN;
            cnt_d   = '0;
         end
      end else if (eff_state == PC_FLUSH) begin
         flush_if_id = 1'b1;
         if (cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = PC_RUN;
            cnt_d   = '0;
         end else begin
            state_d = PC_FLUSH;
            cnt_d   = cnt_q - FLUSH_CNT_W'(1);
         end
      end else begin
         state_d = PC_RUN;
         if (load_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
         end
      end

      // In reset the pipeline registers are held at NOP and nothing redirects.
      if (!rst) begin
         hold_pc          = 1'b0;
         hold_if_id       = 1'b0;
         hold_id_ex       = 1'b0;
         flush_if_id      = 1'b1;
         flush_id_ex      = 1'b1;
         pc_redirect_en   = 1'b0;
         pc_redirect_addr = 32'd0;
      end
   end

   assign stall_evt = hold_pc | hold_if_id | hold_id_ex;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PC_RUN;
         saved_q     <= PC_RUN;
         cnt_q       <= '0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
         if (stall_evt) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (jump_acc)  flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table plus hand sequences
// for reset, mid-FLUSH/mid-BUSY reset and counter wrap.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_rs1_use, id_rs2_use, ex_reg_wen, ex_is_load, ex_jump_en, ex_busy;
   logic [31:0] ex_jump_addr;
   logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_redirect_en;
   logic [31:0] pc_redirect_addr, perf_stall_cnt, perf_flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int illegal_cnt = 0;

   // ctrl bit order: {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_redirect_en}
   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b110010;
   localparam logic [5:0] C_JMP  = 6'b000111;
   localparam logic [5:0] C_FL   = 6'b000100;
   localparam logic [5:0] C_BUSY = 6'b111000;
   localparam logic [5:0] C_RST  = 6'b000110;

   typedef struct {
      logic        busy;
      logic        jmp;
      logic [31:0] ja;
      logic        ld;
      logic        wen;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [5:0]  ctrl;
      logic [31:0] ra;
      logic [31:0] sc;
      logic [31:0] fc;
   } vec_t;

   vec_t tbl[$];

   pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .id_rs1_addr      (id_rs1_addr),
      .id_rs2_addr      (id_rs2_addr),
      .id_rs1_use       (id_rs1_use),
      .id_rs2_use       (id_rs2_use),
      .ex_rd_addr       (ex_rd_addr),
      .ex_reg_wen       (ex_reg_wen),
      .ex_is_load       (ex_is_load),
      .ex_jump_en       (ex_jump_en),
      .ex_jump_addr     (ex_jump_addr),
      .ex_busy          (ex_busy),
      .hold_pc          (hold_pc),
      .hold_if_id       (hold_if_id),
      .hold_id_ex       (hold_id_ex),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .pc_redirect_en   (pc_redirect_en),
      .pc_redirect_addr (pc_redirect_addr),
      .perf_stall_cnt   (perf_stall_cnt),
      .perf_flush_cnt   (perf_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Illegal jump-while-busy stimulus is flagged here; the count is checked at the end.
   always @(posedge clk) begin
      if (rst && ex_busy && ex_jump_en) illegal_cnt++;
   end

   function automatic vec_t mk(input logic busy, input logic jmp, input logic [31:0] ja,
                               input logic ld, input logic wen, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [5:0] ctrl,
                               input logic [31:0] ra, input logic [31:0] sc,
                               input logic [31:0] fc);
      vec_t v;
      v.busy = busy; v.jmp = jmp; v.ja = ja; v.ld = ld; v.wen = wen; v.rd = rd;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.ctrl = ctrl; v.ra = ra; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ex_busy      = v.busy;
      ex_jump_en   = v.jmp;
      ex_jump_addr = v.ja;
      ex_is_load   = v.ld;
      ex_reg_wen   = v.wen;
      ex_rd_addr   = v.rd;
      id_rs1_addr  = v.rs1;
      id_rs2_addr  = v.rs2;
      id_rs1_use   = v.u1;
      id_rs2_use   = v.u2;
   endtask

   task automatic drive_idle();
      drive(mk(0,0,0, 0,0,0,0,0,0,0, C_IDLE,0,0,0));
   endtask

   function automatic logic [31:0] ctrl_now();
      return {26'd0, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_redirect_en};
   endfunction

   initial begin
      // busy,jmp,addr, ld,wen,rd,rs1,rs2,u1,u2 | ctrl, redirect addr, stall cnt, flush cnt
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        0,0)); // 0 idle
      tbl.push_back(mk(0,0,0,         1,1,5,0,5,0,1, C_LU,  0,        0,0)); // 1 load-use rs2
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        1,0)); // 2 bubble done
      tbl.push_back(mk(0,0,0,         1,1,0,0,0,0,1, C_IDLE,0,        1,0)); // 3 rd = x0
      tbl.push_back(mk(0,0,0,         1,1,7,7,3,0,1, C_IDLE,0,        1,0)); // 4 rs1 match unused
      tbl.push_back(mk(0,0,0,         1,1,7,7,3,1,0, C_LU,  0,        1,0)); // 5 load-use rs1
      tbl.push_back(mk(0,0,0,         1,0,9,9,9,1,1, C_IDLE,0,        2,0)); // 6 no wen
      tbl.push_back(mk(0,1,32'h100,   0,0,0,0,0,0,0, C_JMP, 32'h100,  2,0)); // 7 jump
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_FL,  0,        2,1)); // 8 flush tail
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        2,1)); // 9 run
      tbl.push_back(mk(0,1,32'h200,   0,0,0,0,0,0,0, C_JMP, 32'h200,  2,1)); // 10 jump
      tbl.push_back(mk(1,0,0,         0,0,0,0,0,0,0, C_BUSY,0,        2,2)); // 11 busy in FLUSH
      tbl.push_back(mk(1,0,0,         0,0,0,0,0,0,0, C_BUSY,0,        3,2));
      tbl.push_back(mk(1,0,0,         0,0,0,0,0,0,0, C_BUSY,0,        4,2));
      tbl.push_back(mk(1,0,0,         0,0,0,0,0,0,0, C_BUSY,0,        5,2));
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_FL,  0,        6,2)); // 15 resumed flush
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        6,2)); // 16 run
      tbl.push_back(mk(0,1,32'h300,   1,1,5,0,5,0,1, C_JMP, 32'h300,  6,2)); // 17 jump + load-use
      tbl.push_back(mk(0,0,0,         1,1,5,0,5,0,1, C_FL,  0,        6,3)); // 18 no load-use in FLUSH
      tbl.push_back(mk(0,0,0,         1,1,5,0,5,0,1, C_LU,  0,        6,3)); // 19 back in RUN
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        7,3));
      tbl.push_back(mk(1,1,32'h500,   0,0,0,0,0,0,0, C_BUSY,0,        7,3)); // 21 busy + jump
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        8,3)); // 22 BUSY -> RUN
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        8,3));
      tbl.push_back(mk(0,1,32'h400,   0,0,0,0,0,0,0, C_JMP, 32'h400,  8,3)); // 24 jump
      tbl.push_back(mk(0,1,32'h404,   0,0,0,0,0,0,0, C_JMP, 32'h404,  8,4)); // 25 jump in FLUSH
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_FL,  0,        8,5)); // 26 restarted count
      tbl.push_back(mk(0,0,0,         0,0,0,0,0,0,0, C_IDLE,0,        8,5));

      // Reset held for three cycles; a jump during reset must not redirect.
      rst = 1'b0;
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            ex_jump_en   = 1'b1;
            ex_jump_addr = 32'hDEAD_BEEF;
         end else begin
            ex_jump_en   = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("rst%0d_ctrl", i), ctrl_now(), {26'd0, C_RST});
         chk($sformatf("rst%0d_addr", i), pc_redirect_addr, 32'd0);
         chk($sformatf("rst%0d_stall", i), perf_stall_cnt, 32'd0);
         chk($sformatf("rst%0d_flush", i), perf_flush_cnt, 32'd0);
      end
      drive_idle();
      rst = 1'b1;

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("v%0d_ctrl", i), ctrl_now(), {26'd0, tbl[i].ctrl});
         chk($sformatf("v%0d_addr", i), pc_redirect_addr, tbl[i].ra);
         chk($sformatf("v%0d_stall", i), perf_stall_cnt, tbl[i].sc);
         chk($sformatf("v%0d_flush", i), perf_flush_cnt, tbl[i].fc);
      end

      // Reset mid-FLUSH: no resumed flush after release.
      @(posedge clk); #1;
      drive(mk(0,1,32'h600, 0,0,0,0,0,0,0, C_JMP,0,0,0));
      @(negedge clk);
      chk("mflush_jump_ctrl", ctrl_now(), {26'd0, C_JMP});
      @(posedge clk); #1;
      drive_idle();
      #2 rst = 1'b0;
      #1;
      chk("mflush_rst_ctrl", ctrl_now(), {26'd0, C_RST});
      chk("mflush_rst_stall", perf_stall_cnt, 32'd0);
      chk("mflush_rst_flush", perf_flush_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mflush_after_ctrl", ctrl_now(), {26'd0, C_IDLE});

      // Reset mid-BUSY: back in RUN immediately.
      @(posedge clk); #1;
      ex_busy = 1'b1;
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      chk("mbusy_rst_ctrl", ctrl_now(), {26'd0, C_RST});
      ex_busy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mbusy_after_ctrl", ctrl_now(), {26'd0, C_IDLE});
      chk("mbusy_after_stall", perf_stall_cnt, 32'd0);

      // Stall counter wraps from all-ones to zero.
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      chk("wrap_preload", perf_stall_cnt, 32'hFFFF_FFFF);
      drive(mk(0,0,0, 1,1,12,12,0,1,0, C_LU,0,0,0));
      #1;
      chk("wrap_stall_ctrl", ctrl_now(), {26'd0, C_LU});
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("wrap_stall_cnt", perf_stall_cnt, 32'd0);
      chk("wrap_flush_cnt", perf_flush_cnt, 32'd0);

      chk("illegal_busy_jump_seen", illegal_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sequences the IF/ID and ID/EX pipeline registers and the PC by generating hold (stall), flush (NOP insert) and redirect controls. It resolves three hazard sources: multi-cycle EX busy, taken jumps/branches from EX, and load-use dependencies. It also keeps 32-bit stall and flush performance counters.

## Interface
- FLUSH_CYCLES, 2, total cycles IF/ID stays flushed after a taken jump, including the jump cycle; legal range 1..8. Covers synchronous instruction-ROM latency.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_rs1_addr, id_rs2_addr  in  5  source registers of the instruction in ID
- id_rs1_use, id_rs2_use  in  1  the ID instruction actually reads rs1/rs2
- ex_rd_addr  in  5  destination register of the instruction in EX
- ex_reg_wen  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_jump_en  in  1  EX resolved a taken branch/jump this cycle
- ex_jump_addr  in  32  jump target
- ex_busy  in  1  multi-cycle EX unit (div) not done; level signal
- hold_pc, hold_if_id, hold_id_ex  out  1  register keeps its current value
- flush_if_id, flush_id_ex  out  1  register loads `INST_NOP` / zeros next edge
- pc_redirect_en  out  1  PC loads pc_redirect_addr next edge
- pc_redirect_addr  out  32  redirect target
- perf_stall_cnt, perf_flush_cnt  out  32  event counters

## Operation
- FSM states: RUN, FLUSH, BUSY. Control outputs are Mealy (combinational from state + inputs). Counters and FSM are registered.
- Priority per cycle, highest first:
  1. ex_busy.
  2. ex_jump_en.
  3. FLUSH state.
  4. Load-use.
- Busy: hold_pc = hold_if_id = hold_id_ex = 1; no flush or redirect. State goes to BUSY, or stays there while ex_busy = 1. On ex_busy falling, BUSY returns to the state saved on entry (RUN or FLUSH, with the FLUSH count frozen).
- Jump: flush_if_id = flush_id_ex = 1, pc_redirect_en = 1, pc_redirect_addr = ex_jump_addr (pass-through).
  - If FLUSH_CYCLES > 1: load remaining count = FLUSH_CYCLES-1 and go to FLUSH.
  - If FLUSH_CYCLES = 1: stay in RUN.
- FLUSH: flush_if_id = 1 and the count decrements. The state goes to RUN when the count reaches 1 and is being consumed. A jump in FLUSH restarts the count. Load-use is not evaluated in FLUSH.
- Load-use hazard is asserted when ex_is_load & ex_reg_wen & ex_rd_addr != 0 and either:
  - id_rs1_use & rs1 == rd, or
  - id_rs2_use & rs2 == rd.
- Load-use response: hold_pc = hold_if_id = 1 and flush_id_ex = 1 for one cycle (one bubble). The state stays RUN. The bubble clears the EX load, so the hazard self-terminates.
- Counters:
  - perf_stall_cnt += 1 in each cycle where any hold_* output is 1.
  - perf_flush_cnt += 1 in each cycle with ex_jump_en accepted.
  - Both counters wrap at 2^32 with no saturation.
- ex_jump_en while ex_busy = 1 is illegal. It is ignored (busy wins), and the bench flags it with an assertion.
- When no hazard is active, all control outputs are 0 and pc_redirect_addr = 0.

## Timing
- While rst = 0:
  - state = RUN and the count = 0;
  - perf counters = 0;
  - flush_if_id = flush_id_ex = 1, all hold_* = 0, pc_redirect_en = 0, pc_redirect_addr = 0.
- rst deassertion is synchronised externally. The first active edge after release evaluates normally.
- Hazard-to-control latency is 0 cycles (same cycle, combinational). The pipeline registers act on the next rising edge.
- Counter outputs reflect events up to the previous edge (1-cycle latency).
- Reset mid-FLUSH or mid-BUSY forces RUN immediately. No pending redirect survives reset.
- No combinational path from any output back to an input.

## Structure
- Shared package/defines: state encodings (PC_RUN, PC_FLUSH, PC_BUSY) and `INST_NOP`, added to the common defines header.
- Sub-module: hazard_detect, a purely combinational load-use comparator (rs/rd match, x0 exclusion). The FSM, priority mux and counters stay in pipe_ctrl.
- id_ex and if_id gain hold inputs (hold_id_ex, hold_if_id) alongside their existing reset-default behaviour. Flush reuses the NOP default value.

## Test plan
- **Reset:** rst = 0 for 3 cycles → flush_if_id = flush_id_ex = 1, holds = 0, counters 0. After release with idle inputs → all controls 0.
- **Load-use:** ex_is_load = 1, ex_reg_wen = 1, ex_rd_addr = 5, id_rs2_addr = 5, id_rs2_use = 1.
  - Expect: exactly one cycle of hold_pc = hold_if_id = flush_id_ex = 1, then perf_stall_cnt = 1.
  - Repeat with ex_rd_addr = 0 → no stall.
- **Jump, FLUSH_CYCLES = 2:** ex_jump_en = 1, ex_jump_addr = 0x0000_0100.
  - Cycle 0: redirect_en = 1, addr = 0x100, both flushes = 1.
  - Cycle 1: flush_if_id = 1 only.
  - Cycle 2: all 0; perf_flush_cnt = 1.
- **Busy during FLUSH:** jump, then ex_busy = 1 for 4 cycles in the next cycle.
  - Expect: holds = 1 and no flush during busy, then one resumed flush_if_id cycle, then RUN.
  - perf_stall_cnt = 4.
- **Simultaneous events:** ex_jump_en together with a load-use match → jump response only, no holds. ex_busy together with ex_jump_en → holds only, no redirect.
- **Counter wrap:** preload perf_stall_cnt to 0xFFFF_FFFF (force), apply one stall → 0x0000_0000.
